// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract controller that drives one shared external full adder,
// processing one operand bit per clock, LSB first, and collecting sum, carry and overflow.
module serial_addsub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c,
  input  logic             fa_sm,
  input  logic             fa_cr
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             last_bit;

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // The full adder only sees live operand bits while a bit is actually being processed.
  assign fa_a = busy & a_sh[0];
  assign fa_b = busy & b_sh[0];
  assign fa_c = busy & carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh      <= '0;
      b_sh      <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
            a_sh      <= op_a;
            b_sh      <= sub ? ~op_b : op_b;
            carry     <= sub;
            cnt       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
          end
        end
        RUN: begin
          // Shift form avoids an empty slice when WIDTH is 1.
          result <= (result >> 1) | (WIDTH'(fa_sm) << (WIDTH - 1));
          carry  <= fa_cr;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          cnt    <= cnt + 1'b1;
          if (last_bit) begin
            carry_out <= fa_cr;
            overflow  <= carry ^ fa_cr;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench: an 8-bit instance with a cycle-level arithmetic model and a
// compare process every cycle, plus directed literal cases and a 1-bit instance.
module tb_serial_addsub_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0, sub = 1'b0;
  logic [W-1:0] op_a = '0, op_b = '0;
  logic         busy, done, carry_out, overflow, fa_a, fa_b, fa_c, fa_sm, fa_cr;
  logic [W-1:0] result;

  logic         start1 = 1'b0, sub1 = 1'b0;
  logic [0:0]   a1 = '0, b1 = '0, result1;
  logic         busy1, done1, co1, ov1, fa_a1, fa_b1, fa_c1, fa_sm1, fa_cr1;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  // The shared full-adder cells.
  assign fa_sm  = fa_a ^ fa_b ^ fa_c;
  assign fa_cr  = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);
  assign fa_sm1 = fa_a1 ^ fa_b1 ^ fa_c1;
  assign fa_cr1 = (fa_a1 & fa_b1) | (fa_a1 & fa_c1) | (fa_b1 & fa_c1);

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result), .carry_out(carry_out), .overflow(overflow),
    .fa_a(fa_a), .fa_b(fa_b), .fa_c(fa_c), .fa_sm(fa_sm), .fa_cr(fa_cr)
  );

  serial_addsub_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .op_a(a1), .op_b(b1),
    .busy(busy1), .done(done1), .result(result1), .carry_out(co1), .overflow(ov1),
    .fa_a(fa_a1), .fa_b(fa_b1), .fa_c(fa_c1), .fa_sm(fa_sm1), .fa_cr(fa_cr1)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: cycles elapsed since acceptance plus the arithmetic outcome.
  int           phase = 0;   // 0 idle, 1..W processing bit phase-1, W+1 done pulse
  longint       ma = 0, mb = 0, msum = 0;
  logic [W-1:0] fin_res = '0, hold_res = '0;
  logic         fin_co = 1'b0, fin_ov = 1'b0, hold_co = 1'b0, hold_ov = 1'b0;

  function automatic longint to_signed(input longint v, input int w);
    return v[w-1] ? v - (longint'(1) << w) : v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase = 0; hold_res = '0; hold_co = 1'b0; hold_ov = 1'b0;
    end else if (phase == 0) begin
      if (start) begin
        longint sv;
        ma   = longint'(op_a);
        mb   = sub ? longint'(~op_b) : longint'(op_b);
        msum = ma + mb + longint'(sub);
        sv   = sub ? to_signed(ma, W) - to_signed(longint'(op_b), W)
                   : to_signed(ma, W) + to_signed(longint'(op_b), W);
        fin_res  = msum[W-1:0];
        fin_co   = sub ? (op_a >= op_b) : ((longint'(op_a) + longint'(op_b)) >= (longint'(1) << W));
        fin_ov   = (sv < -(longint'(1) << (W - 1))) || (sv > (longint'(1) << (W - 1)) - 1);
        hold_res = '0; hold_co = 1'b0; hold_ov = 1'b0;
        phase    = 1;
      end
    end else if (phase <= W) begin
      phase++;
      if (phase == W + 1) begin
        hold_res = fin_res; hold_co = fin_co; hold_ov = fin_ov;
      end
    end else begin
      phase = 0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      bit run;
      run = (phase >= 1) && (phase <= W);
      check("busy", busy, run);
      check("done", done, phase == W + 1);
      if (run) begin
        int     k;
        longint part;
        k    = phase - 1;
        part = (k == 0) ? 0 : ((msum & ((longint'(1) << k) - 1)) << (W - k));
        check("fa_a", fa_a, (ma >> k) & 1);
        check("fa_b", fa_b, (mb >> k) & 1);
        check("fa_c", fa_c, ((msum ^ ma ^ mb) >> k) & 1);
        check("partial_result", result, part & ((longint'(1) << W) - 1));
      end else begin
        check("fa_idle", {fa_a, fa_b, fa_c}, 3'b000);
        check("result", result, hold_res);
        check("carry_out", carry_out, hold_co);
        check("overflow", overflow, hold_ov);
      end
    end
  end

  // Issue one operation, scramble inputs after acceptance, wait (bounded) for done.
  task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [W-1:0] er, input logic eco, input logic eov);
    bit seen;
    @(posedge clk); #1;
    op_a = a; op_b = b; sub = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op_a = W'($urandom); op_b = W'($urandom); sub = 1'($urandom);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    check({nm, "_done_seen"}, seen, 1'b1);
    check({nm, "_result"}, result, er);
    check({nm, "_carry"}, carry_out, eco);
    check({nm, "_ovf"}, overflow, eov);
  endtask

  initial begin
    #23 rst_n = 1'b1;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_result", result, '0);
    cmp_en = 1'b1;

    // Literal expectations pinning the arithmetic.
    run_op("add_3c_15", 8'h3C, 8'h15, 1'b0, 8'h51, 1'b0, 1'b0);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("sub_05_07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    run_op("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

    // Start pulse during RUN is ignored; operand changes after acceptance are harmless.
    begin
      bit seen;
      int extra;
      @(posedge clk); #1;
      op_a = 8'h10; op_b = 8'h20; sub = 1'b0; start = 1'b1;
      @(posedge clk); #1;   // E0
      start = 1'b0;
      @(posedge clk); #1;   // E1
      @(posedge clk); #1;   // E2
      op_a = 8'hAA; op_b = 8'h55; start = 1'b1;
      @(posedge clk); #1;   // E3
      start = 1'b0;
      @(posedge clk); #1;   // E4
      op_a = 8'hC3;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(posedge clk); #1;
        if (done) seen = 1'b1;
      end
      check("ignored_done_seen", seen, 1'b1);
      check("ignored_result", result, 8'h30);
      extra = 0;
      repeat (10) begin
        @(posedge clk); #1;
        if (done) extra++;
      end
      check("ignored_single_done", extra, 0);
    end

    // Asynchronous abort mid-operation.
    @(posedge clk); #1;
    op_a = 8'h55; op_b = 8'h0F; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_result", result, '0);
    check("abort_fa", {fa_a, fa_b, fa_c}, 3'b000);
    #10 rst_n = 1'b1;
    run_op("after_abort", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

    // Randomized traffic, including start requests while busy.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 2) == 0);
      op_a  = W'($urandom);
      op_b  = W'($urandom);
      sub   = 1'($urandom);
    end
    @(posedge clk); #1;
    start = 1'b0;
    repeat (W + 4) @(posedge clk);
    #1;

    // One-bit build, all operand combinations.
    for (int i = 0; i < 8; i++) begin
      logic   ea, eb, es, er, eco, eov;
      longint sa, sb, sv;
      ea = 1'(i); eb = 1'(i >> 1); es = 1'(i >> 2);
      sa = ea ? -1 : 0;
      sb = eb ? -1 : 0;
      sv = es ? sa - sb : sa + sb;
      er  = es ? (ea ^ eb) : (ea ^ eb);
      eco = es ? (ea >= eb) : (ea & eb);
      eov = (sv < -1) || (sv > 0);
      @(posedge clk); #1;
      a1 = ea; b1 = eb; sub1 = es; start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0; a1 = ~ea;
      check("w1_busy", busy1, 1'b1);
      check("w1_fa_c", fa_c1, es);
      @(posedge clk); #1;
      check("w1_done", done1, 1'b1);
      check("w1_result", result1, er);
      check("w1_carry", co1, eco);
      check("w1_ovf", ov1, eov);
      @(posedge clk); #1;
      check("w1_done_end", done1, 1'b0);
    end

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_addsub_ctrl.md
Name: serial_addsub_ctrl

Overview:
Controller that time-multiplexes one external 1-bit full adder (a, b, c -> sm, cr) to perform WIDTH-bit two's-complement addition or subtraction, one bit per clock, LSB first. It latches the operands on a start pulse and drives the full adder's inputs from internal shift registers. It collects the sum bits and the final carry. It reports completion with a one-cycle done pulse. It sits between a requesting sequencer and the shared full-adder cell.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
sub  input  1  0 = A+B, 1 = A-B; sampled with start
op_a  input  WIDTH  operand A; sampled with start
op_b  input  WIDTH  operand B; sampled with start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; result fields valid
result  output  WIDTH  sum/difference
carry_out  output  1  final carry; for subtraction, 1 = no borrow
overflow  output  1  signed overflow of the operation
fa_a  output  1  to full adder input a
fa_b  output  1  to full adder input b
fa_c  output  1  to full adder carry-in
fa_sm  input  1  from full adder sum
fa_cr  input  1  from full adder carry-out

Behaviour:
- One clock domain; reset is asynchronous, active-low (rst_n).
- Reset: state IDLE; busy, done, result, carry_out, overflow all 0; internal shift registers, carry and bit counter 0; fa_a/fa_b/fa_c 0.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on an edge with start=1:
  - a_sh <= op_a.
  - b_sh <= sub ? ~op_b : op_b.
  - carry <= sub.
  - cnt <= 0.
  - result cleared to 0.
- RUN outputs (combinational from registers only): fa_a = a_sh[0], fa_b = b_sh[0], fa_c = carry.
- RUN, each edge:
  - result <= {fa_sm, result[WIDTH-1:1]}.
  - carry <= fa_cr.
  - a_sh and b_sh shift right by 1.
  - cnt <= cnt+1.
- RUN, edge with cnt = WIDTH-1:
  - carry_out <= fa_cr.
  - overflow <= fa_c ^ fa_cr (carry into MSB xor carry out of MSB).
  - Go to DONE.
- DONE: done=1 for exactly one cycle, then unconditional return to IDLE.
- Result fields: result, carry_out and overflow hold their values after DONE until the next accepted start.
- Latency: start accepted at edge E0. Bits are processed on edges E1..E_WIDTH. done is high in the cycle after E_WIDTH. Next start can be accepted at E_WIDTH+2.
- busy = 1 exactly in RUN (WIDTH cycles). fa_a/fa_b/fa_c = 0 outside RUN.
- start while in RUN or DONE is ignored and not queued. op_a/op_b/sub may change freely after acceptance with no effect.
- WIDTH = 1: a single RUN cycle, then DONE; overflow = fa_c ^ fa_cr of that bit.
- Any mid-operation rst_n assertion aborts immediately to the reset values. No done pulse is produced.
- Arithmetic is modulo 2^WIDTH. overflow uses signed interpretation of both operands.

Test Plan:
- WIDTH=8, start with sub=0, op_a=0x3C, op_b=0x15 at E0 -> busy high E0..E8; done high only between E8 and E9; result=0x51, carry_out=0, overflow=0. fa_a sequence LSB-first 0,0,1,1,1,1,0,0.
- Add 0xFF+0x01 -> result=0x00, carry_out=1, overflow=0. Add 0x7F+0x01 -> result=0x80, carry_out=0, overflow=1.
- Subtract 0x05-0x07 -> result=0xFE, carry_out=0 (borrow), overflow=0. Subtract 0x80-0x01 -> result=0x7F, carry_out=1, overflow=1. fa_c=1 in the first RUN cycle of both.
- Start 0x10+0x20, then pulse start with 0xAA/0x55 at E3 and change op_a at E4 -> second request ignored; result=0x30, single done pulse.
- Assert rst_n low at E4 of an operation -> busy, done, result, fa_* = 0 immediately (asynchronously). After release, a new 0x01+0x01 yields 0x02 with full latency.
- WIDTH=1 build: 1+1 -> result=0, carry_out=1, overflow=1, done in the cycle after E1.
